fsqrt_share_arb: RTL and testbench

- Round-robin arbiter that shares one fully pipelined, non-stallable fsqrt datapath (fixed 3-cycle latency, one issue per clock) between NREQ requesters.
- Accepts one operand per cycle via valid/ready, drives the unit's operand input, and tracks requester IDs through a tag pipeline matched to the unit latency.
- Returns each result into a per-requester holding register with a valid/ready handshake.
- Sits between FPU issue ports (e.g. multiple pipeline lanes) and the single fsqrt instance.

---
 rtl/fsqrt_share_arb_if.sv | 26 ++
 rtl/fsqrt_share_arb.sv | 134 +++++++++++++
 tb/tb_fsqrt_share_arb.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fsqrt_share_arb_if.sv
// fsqrt_share_arb_if: bundle between requesters, the shared fsqrt unit and the arbiter.
// Signals: req_valid/req_data/req_ready (issue), rsp_valid/rsp_data/rsp_ready (return), sq_x/sq_y (unit).
interface fsqrt_share_arb_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [32*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic [31:0]          sq_x;
    logic [31:0]          sq_y;
    logic [NREQ-1:0]      rsp_valid;
    logic [32*NREQ-1:0]   rsp_data;
    logic [NREQ-1:0]      rsp_ready;

    // master: requesters plus the fsqrt unit (everything around the arbiter)
    modport master (
        output req_valid, req_data, rsp_ready, sq_y,
        input  req_ready, sq_x, rsp_valid, rsp_data
    );

    // slave: the arbiter
    modport slave (
        input  req_valid, req_data, rsp_ready, sq_y,
        output req_ready, sq_x, rsp_valid, rsp_data
    );
endinterface

// File: rtl/fsqrt_share_arb.sv
// fsqrt_share_arb: round-robin sharing of one non-stallable fsqrt pipe among NREQ requesters.
// Ports: clk, rst (async, active-high), bus (fsqrt_share_arb_if.slave). Option: FSQRT_ARB_NEGCHK_EN.
module fsqrt_share_arb #(
    parameter int NREQ = 4,
    parameter int LAT  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    fsqrt_share_arb_if.slave      bus
);
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NST = LAT + 1;

    logic [IW-1:0]    r_ptr;
    logic [NST-1:0]   r_tv;
    logic [IW-1:0]    r_tid [NST];
    logic [NREQ-1:0]  r_rsp_valid;
    logic [31:0]      r_rsp_data [NREQ];

    logic [NREQ-1:0]  w_busy;
    logic [NREQ-1:0]  w_elig;
    logic             w_gnt_any;
    logic [IW-1:0]    w_gnt_id;
    logic [IW-1:0]    w_ptr_nxt;
    logic [NREQ-1:0]  w_ready;
    logic [31:0]      w_sq_x;
    logic [31:0]      w_cap_data;
    int               w_idx;

`ifdef FSQRT_ARB_NEGCHK_EN
    logic [NST-1:0]   r_tnan;
    logic             w_nan_in;

    // negative, non-zero-exponent operand: result is replaced by a quiet NaN
    assign w_nan_in   = w_sq_x[31] & (|w_sq_x[30:23]);
    assign w_cap_data = r_tnan[LAT] ? 32'h7FC0_0000 : bus.sq_y;
`else
    assign w_cap_data = bus.sq_y;
`endif

    // a requester is busy from issue until its held result is drained
    always_comb begin
        w_busy = r_rsp_valid;
        for (int s = 0; s < NST; s++) begin
            if (r_tv[s]) begin
                w_busy[r_tid[s]] = 1'b1;
            end
        end
    end

    assign w_elig = bus.req_valid & ~w_busy & {NREQ{~rst}};

    // rotating priority scan starting at r_ptr
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        w_idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NREQ;
            if (!w_gnt_any && w_elig[w_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = IW'(w_idx);
            end
        end
    end

    assign w_ptr_nxt = (int'(w_gnt_id) == NREQ - 1) ? '0 : w_gnt_id + 1'b1;

    always_comb begin
        w_ready = '0;
        w_sq_x  = '0;
        if (w_gnt_any) begin
            w_ready[w_gnt_id] = 1'b1;
            w_sq_x = bus.req_data[int'(w_gnt_id)*32 +: 32];
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.sq_x      = w_sq_x;
    assign bus.rsp_valid = r_rsp_valid;

    for (genvar g = 0; g < NREQ; g++) begin : g_rsp
        assign bus.rsp_data[32*g +: 32] = r_rsp_data[g];
    end

    // pointer and tag pipeline; tags shift every edge since the unit never stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
            r_tv  <= '0;
            for (int s = 0; s < NST; s++) begin
                r_tid[s] <= '0;
            end
        end else begin
            if (w_gnt_any) begin
                r_ptr <= w_ptr_nxt;
            end
            r_tv     <= {r_tv[NST-2:0], w_gnt_any};
            r_tid[0] <= w_gnt_id;
            for (int s = 1; s < NST; s++) begin
                r_tid[s] <= r_tid[s-1];
            end
        end
    end

`ifdef FSQRT_ARB_NEGCHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tnan <= '0;
        end else begin
            r_tnan <= {r_tnan[NST-2:0], w_gnt_any & w_nan_in};
        end
    end
`endif

    // per-requester holding registers; capture cannot meet a held result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= '0;
            for (int i = 0; i < NREQ; i++) begin
                r_rsp_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (r_tv[LAT] && (r_tid[LAT] == IW'(i))) begin
                    r_rsp_valid[i] <= 1'b1;
                    r_rsp_data[i]  <= w_cap_data;
                end else if (r_rsp_valid[i] && bus.rsp_ready[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fsqrt_share_arb.sv
// tb_fsqrt_share_arb: random and directed checks of fsqrt_share_arb against a scoreboard model.
// Includes a stand-in fsqrt unit whose result appears on sq_y LAT+1 edges after issue.
module tb_fsqrt_share_arb;
    localparam int NREQ = 4;
    localparam int LAT  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    fsqrt_share_arb_if #(.NREQ(NREQ)) bus ();

    fsqrt_share_arb #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // golden square roots for the directed operands, cheap approximation otherwise
    function automatic logic [31:0] sq_fn(input logic [31:0] x);
        case (x)
            32'h3F80_0000: return 32'h3F80_0000;
            32'h4080_0000: return 32'h4000_0000;
            32'h4110_0000: return 32'h4040_0000;
            32'h4180_0000: return 32'h4080_0000;
            32'h0000_0000: return 32'h0000_0000;
            32'h8000_0000: return 32'h8000_0000;
            32'hC080_0000: return 32'hFFC0_0000;
            default:       return (x >> 1) + 32'h1FC0_0000;
        endcase
    endfunction

    function automatic logic [31:0] exp_res(input logic [31:0] x);
`ifdef FSQRT_ARB_NEGCHK_EN
        if (x[31] && x[30:23] != 8'h00) return 32'h7FC0_0000;
`endif
        return sq_fn(x);
    endfunction

    logic [31:0] u_pipe [LAT+1];
    always @(posedge clk) begin
        u_pipe[0] <= sq_fn(bus.sq_x);
        for (int j = 1; j <= LAT; j++) u_pipe[j] <= u_pipe[j-1];
    end
    assign bus.sq_y = u_pipe[LAT];

    // scoreboard: age of each outstanding op (-1 none), held results, pointer
    int          m_age   [NREQ];
    bit          m_held  [NREQ];
    logic [31:0] m_hdata [NREQ];
    logic [31:0] m_exp   [NREQ];
    int          m_ptr;
    bit          m_gnt;
    int          m_gid;
    logic [NREQ-1:0] s_vld, s_rdy;
    logic [31:0]     s_data [NREQ];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < NREQ; i++) begin
            m_age[i] = -1; m_held[i] = 0; m_hdata[i] = '0; m_exp[i] = '0;
        end
    endtask

    task automatic set_data(input int i, input logic [31:0] v);
        bus.req_data[32*i +: 32] = v;
    endtask

    // one clock: check mid-cycle, then advance the model at the edge
    task automatic step();
        logic [NREQ-1:0] e_rdy;
        logic [31:0]     e_sqx;
        @(negedge clk);
        s_vld = bus.req_valid;
        s_rdy = bus.rsp_ready;
        for (int i = 0; i < NREQ; i++) s_data[i] = bus.req_data[32*i +: 32];
        m_gnt = 0; m_gid = 0;
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (!m_gnt && s_vld[i] && m_age[i] < 0 && !m_held[i]) begin
                    m_gnt = 1; m_gid = i;
                end
            end
        end
        e_rdy = '0; e_sqx = '0;
        if (m_gnt) begin e_rdy[m_gid] = 1'b1; e_sqx = s_data[m_gid]; end
        chk("req_ready", 32'(bus.req_ready), 32'(e_rdy));
        chk("sq_x", bus.sq_x, e_sqx);
        for (int i = 0; i < NREQ; i++) begin
            chk($sformatf("rsp_valid%0d", i), 32'(bus.rsp_valid[i]), 32'(m_held[i]));
            chk($sformatf("rsp_data%0d", i), bus.rsp_data[32*i +: 32], m_hdata[i]);
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < NREQ; i++) if (m_held[i] && s_rdy[i]) m_held[i] = 0;
            for (int i = 0; i < NREQ; i++) begin
                if (m_age[i] >= 0) begin
                    m_age[i]++;
                    if (m_age[i] == LAT + 1) begin
                        m_held[i] = 1; m_hdata[i] = m_exp[i]; m_age[i] = -1;
                    end
                end
            end
            if (m_gnt) begin
                m_age[m_gid] = 0;
                m_exp[m_gid] = exp_res(s_data[m_gid]);
                m_ptr = (m_gid + 1) % NREQ;
            end
        end
        #1;
    endtask

    function automatic logic [31:0] rnd_op();
        logic [31:0] tbl [7];
        tbl = '{32'h3F80_0000, 32'h4080_0000, 32'h4110_0000, 32'h4180_0000,
                32'h0000_0000, 32'h8000_0000, 32'hC080_0000};
        if ($urandom_range(0, 2) == 0) return tbl[$urandom_range(0, 6)];
        return $urandom;
    endfunction

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = '0;
        model_reset();
        #1 rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;

        // all four valid from reset
        bus.req_valid = 4'b1111;
        set_data(0, 32'h3F80_0000); set_data(1, 32'h4080_0000);
        set_data(2, 32'h4110_0000); set_data(3, 32'h4180_0000);
        bus.rsp_ready = 4'b1111;
        step();
        bus.req_valid = 4'b0000;
        repeat (8) step();

        // single requester timing
        bus.req_valid = 4'b0001;
        set_data(0, 32'h4080_0000);
        bus.rsp_ready = 4'b0000;
        step();
        bus.req_valid = 4'b0000;
        repeat (4) step();
        chk("single_valid", 32'(bus.rsp_valid[0]), 32'd1);
        chk("single_data", bus.rsp_data[31:0], 32'h4000_0000);
        bus.rsp_ready = 4'b0001;
        step();
        bus.rsp_ready = 4'b0000;

        // zero input
        bus.req_valid = 4'b0001;
        set_data(0, 32'h0000_0000);
        step();
        bus.req_valid = 4'b0000;
        repeat (4) step();
        chk("zero_data", bus.rsp_data[31:0], 32'h0000_0000);
        bus.rsp_ready = 4'b1111;
        step();

        // backpressure on requester 1
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 4'b1101;
        repeat (20) begin
            for (int i = 0; i < NREQ; i++) set_data(i, rnd_op());
            step();
        end
        bus.rsp_ready = 4'b1111;
        repeat (10) step();

        // negative operands
        bus.req_valid = 4'b0000;
        repeat (8) step();
        bus.req_valid = 4'b0011;
        set_data(0, 32'hC080_0000); set_data(1, 32'h8000_0000);
        bus.rsp_ready = 4'b0000;
        step(); step();
        bus.req_valid = 4'b0000;
        repeat (4) step();
`ifdef FSQRT_ARB_NEGCHK_EN
        chk("neg4", bus.rsp_data[31:0], 32'h7FC0_0000);
`else
        chk("neg4", bus.rsp_data[31:0], 32'hFFC0_0000);
`endif
        chk("negzero", bus.rsp_data[63:32], 32'h8000_0000);
        bus.rsp_ready = 4'b1111;
        repeat (3) step();

        // reset with three ops in flight and one held
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 4'b0000;
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_sq_x", bus.sq_x, 32'd0);
        model_reset();
        repeat (2) step();
        rst = 1'b0;
        bus.req_valid = 4'b0110;
        bus.rsp_ready = 4'b1111;
        #3;
        chk("rst_first_gnt", 32'(bus.req_ready), 32'h2);
        repeat (10) step();

        // random traffic
        repeat (400) begin
            bus.req_valid = 4'($urandom);
            bus.rsp_ready = 4'($urandom) | 4'($urandom);
            for (int i = 0; i < NREQ; i++) set_data(i, rnd_op());
            step();
        end
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        repeat (8) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
